// File: rtl/divmod_recompose.sv
// Rebuilds a dividend from a (quotient, remainder) pair as q*DIVISOR + r using a
// serial shift-and-add multiplier. Define DIVMOD_RECOMPOSE_EARLY_TERM_EN to stop once q is exhausted.
module divmod_recompose #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIVISOR = WIDTH'(1234101)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] r_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic             ovf,
    output logic             rem_err
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [AW-1:0] DIV_EXT = AW'(DIVISOR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_sr_q;
    logic [WIDTH-1:0] q_sr_d;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_d;
    logic [AW-1:0]    add_term_s;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             last_calc_s;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_out_q;
    logic             ovf_q;
    logic             rem_err_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign a_out     = a_out_q;
    assign ovf       = ovf_q;
    assign rem_err   = rem_err_q;

    // One multiplier step: conditional add of the shifted divisor, then shift q and bump the counter.
    always_comb begin
        add_term_s = '0;
        if (q_sr_q[0]) begin
            add_term_s = DIV_EXT << cnt_q;
        end else begin
            add_term_s = '0;
        end
        acc_d  = acc_q + add_term_s;
        q_sr_d = q_sr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
`ifdef DIVMOD_RECOMPOSE_EARLY_TERM_EN
        // Post-shift check: the bit consumed this cycle has already been added.
        last_calc_s = (cnt_q == CW'(WIDTH - 1)) || (q_sr_d == '0);
`else
        last_calc_s = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            q_sr_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_out_q     <= '0;
            ovf_q       <= 1'b0;
            rem_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        q_sr_q     <= q_in;
                        acc_q      <= AW'(r_in);
                        cnt_q      <= '0;
                        rem_err_q  <= (r_in >= DIVISOR);
                        in_ready_q <= 1'b0;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q  <= acc_d;
                    q_sr_q <= q_sr_d;
                    cnt_q  <= cnt_d;
                    if (last_calc_s) begin
                        a_out_q     <= acc_d[WIDTH-1:0];
                        ovf_q       <= |acc_d[AW-1:WIDTH];
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        ovf_q       <= 1'b0;
                        rem_err_q   <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    ovf_q       <= 1'b0;
                    rem_err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
